// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants and the requester-id encoding for the register bank arbiter.
package reg_bank_arbiter_pkg;

    localparam int unsigned DW = 32;  // bank register / write data width
    localparam int unsigned CW = 16;  // committed-write counter width

    typedef enum logic {
        Req0 = 1'b0,
        Req1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/bank_reg32.sv
// One 32-bit bank entry: synchronous clear, load-enabled capture, otherwise hold.
module bank_reg32
    import reg_bank_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    // Next value: clear wins over load, load wins over hold.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin write arbiter in front of a register bank. A winner is
// captured into a single write stage and committed to the bank one edge later, so
// capture and commit overlap for one write per cycle. Reads bypass the write stage.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned NREG = 8,  // power of two, 2..16
    parameter int unsigned AW   = 3   // must equal log2(NREG)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          req0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    output logic          gnt1,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd,
    output logic [CW-1:0] wcnt
);

    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    req_id_e       ptr_q, ptr_d;
    logic          pend_vld_q, pend_vld_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [CW-1:0] wcnt_q, wcnt_d;

    logic          elig0, elig1, grant;
    req_id_e       win;
    logic [DW-1:0] bank_q [NREG];

    // Arbitration, write-stage capture, pointer update and commit counting.
    always_comb begin
        // A requester whose grant is showing this cycle is still holding req; skip it.
        elig0       = req0 & ~gnt0_q;
        elig1       = req1 & ~gnt1_q;
        grant       = elig0 | elig1;
        win         = Req0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        ptr_d       = ptr_q;
        pend_vld_d  = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wcnt_d      = wcnt_q + CW'(pend_vld_q);

        if (elig0 && elig1) begin
            win = ptr_q;
        end else if (elig1) begin
            win = Req1;
        end

        if (grant) begin
            pend_vld_d = 1'b1;
            if (win == Req0) begin
                gnt0_d      = 1'b1;
                ptr_d       = Req1;
                pend_addr_d = wa0;
                pend_data_d = wd0;
            end else begin
                gnt1_d      = 1'b1;
                ptr_d       = Req0;
                pend_addr_d = wa1;
                pend_data_d = wd1;
            end
        end

        // Clear discards any pending write and beats both capture and commit.
        if (clear) begin
            gnt0_d     = 1'b0;
            gnt1_d     = 1'b0;
            ptr_d      = Req0;
            pend_vld_d = 1'b0;
            wcnt_d     = '0;
        end
    end

    // Arbiter, pointer, write-stage and counter state.
    always_ff @(posedge clk) begin
        gnt0_q      <= gnt0_d;
        gnt1_q      <= gnt1_d;
        ptr_q       <= ptr_d;
        pend_vld_q  <= pend_vld_d;
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
        wcnt_q      <= wcnt_d;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_bank
        bank_reg32 u_bank (
            .clk   (clk),
            .clear (clear),
            .load  (pend_vld_q && (pend_addr_q == AW'(i))),
            .d     (pend_data_q),
            .q     (bank_q[i])
        );
    end

    assign rd   = (pend_vld_q && (pend_addr_q == ra)) ? pend_data_q : bank_q[ra];
    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign wcnt = wcnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed vector bench for reg_bank_arbiter: a table of per-cycle inputs with
// hand-computed post-edge outputs, plus fairness and counter-wrap sequences.
module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic        req0, req1;
    logic [2:0]  wa0, wa1, ra;
    logic [31:0] wd0, wd1;
    logic        gnt0, gnt1;
    logic [31:0] rd;
    logic [15:0] wcnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .NREG (8),
        .AW   (3)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .req0  (req0),
        .wa0   (wa0),
        .wd0   (wd0),
        .gnt0  (gnt0),
        .req1  (req1),
        .wa1   (wa1),
        .wd1   (wd1),
        .gnt1  (gnt1),
        .ra    (ra),
        .rd    (rd),
        .wcnt  (wcnt)
    );

    typedef struct {
        logic        clr;
        logic        r0;
        logic [2:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic [2:0]  a1;
        logic [31:0] d1;
        logic [2:0]  ra;
        logic        g0;
        logic        g1;
        logic [31:0] rd;
        logic [15:0] wc;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(logic clr, logic r0, logic [2:0] a0, logic [31:0] d0,
                                logic r1, logic [2:0] a1, logic [31:0] d1, logic [2:0] ra,
                                logic g0, logic g1, logic [31:0] rdx, logic [15:0] wc);
        vec_t v;
        v.clr = clr; v.r0 = r0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.d1 = d1; v.ra = ra;
        v.g0 = g0; v.g1 = g1; v.rd = rdx; v.wc = wc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic r0, input logic [2:0] a0,
                         input logic [31:0] d0, input logic r1, input logic [2:0] a1,
                         input logic [31:0] d1, input logic [2:0] rax);
        clear = clr; req0 = r0; wa0 = a0; wd0 = d0;
        req1 = r1; wa1 = a1; wd1 = d1; ra = rax;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int g0_cnt, g1_cnt;

    initial begin
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd0);

        //          clr r0 a0 d0            r1 a1 d1     ra  g0 g1 rd            wc
        vt[0]  = mk(1, 1, 3, 32'h1,        1, 0, 32'h2, 0,  0, 0, 32'h0,        0);
        vt[1]  = mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0, 3,  1, 0, 32'hDEADBEEF, 0);
        vt[2]  = mk(0, 1, 7, 32'hFFFFFFFF, 0, 0, 32'h0, 3,  0, 0, 32'hDEADBEEF, 1);
        vt[3]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 3,  0, 0, 32'hDEADBEEF, 1);
        vt[4]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0, 3,  0, 0, 32'h0,        0);
        vt[5]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22, 1, 1, 0, 32'h11,       0);
        vt[6]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22, 2, 0, 1, 32'h22,       1);
        vt[7]  = mk(0, 0, 0, 32'h0,        1, 2, 32'h22, 1, 0, 0, 32'h11,       2);
        vt[8]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 2,  0, 0, 32'h22,       2);
        vt[9]  = mk(0, 0, 0, 32'h0,        1, 5, 32'hA, 5,  0, 1, 32'hA,        2);
        vt[10] = mk(0, 1, 5, 32'hB,        1, 5, 32'hA, 5,  1, 0, 32'hB,        3);
        vt[11] = mk(0, 1, 5, 32'hB,        0, 0, 32'h0, 5,  0, 0, 32'hB,        4);
        vt[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 5,  0, 0, 32'hB,        4);
        vt[13] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 0,  0, 0, 32'h0,        4);
        vt[14] = mk(0, 1, 6, 32'hC0,       1, 7, 32'hD1, 7, 0, 1, 32'hD1,       4);
        vt[15] = mk(0, 1, 6, 32'hC0,       1, 7, 32'hD1, 6, 1, 0, 32'hC0,       5);
        vt[16] = mk(0, 1, 6, 32'hC0,       0, 0, 32'h0, 7,  0, 0, 32'hD1,       6);
        vt[17] = mk(0, 1, 4, 32'h55,       0, 0, 32'h0, 4,  1, 0, 32'h55,       6);
        vt[18] = mk(1, 1, 4, 32'h55,       0, 0, 32'h0, 4,  0, 0, 32'h0,        0);
        vt[19] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 4,  0, 0, 32'h0,        0);
        vt[20] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 5,  0, 0, 32'h0,        0);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].clr, vt[i].r0, vt[i].a0, vt[i].d0,
                  vt[i].r1, vt[i].a1, vt[i].d1, vt[i].ra);
            step();
            check($sformatf("v%0d.gnt0", i), 32'(gnt0), 32'(vt[i].g0));
            check($sformatf("v%0d.gnt1", i), 32'(gnt1), 32'(vt[i].g1));
            check($sformatf("v%0d.rd", i), rd, vt[i].rd);
            check($sformatf("v%0d.wcnt", i), 32'(wcnt), 32'(vt[i].wc));
        end

        // Fairness: both requesters re-request at once, grants must alternate from 0.
        drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd0);
        step();
        g0_cnt = 0;
        g1_cnt = 0;
        drive(1'b0, 1'b1, 3'd0, 32'h100, 1'b1, 3'd1, 32'h200, 3'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("fair%0d.gnt0", k), 32'(gnt0), 32'((k % 2) == 0));
            check($sformatf("fair%0d.gnt1", k), 32'(gnt1), 32'((k % 2) == 1));
            g0_cnt += int'(gnt0);
            g1_cnt += int'(gnt1);
        end
        check("fair.count0", 32'(g0_cnt), 32'd5);
        check("fair.count1", 32'(g1_cnt), 32'd5);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd1);
        step();
        check("fair.wcnt", 32'(wcnt), 32'd10);
        check("fair.rd1", rd, 32'h200);

        // Counter wrap: 65536 back-to-back writes from reset.
        drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd0);
        step();
        drive(1'b0, 1'b1, 3'd2, 32'h3, 1'b1, 3'd3, 32'h4, 3'd0);
        for (int k = 0; k < 65536; k++) begin
            step();
        end
        check("wrap.pre", 32'(wcnt), 32'h0000FFFF);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd0);
        step();
        check("wrap.wcnt", 32'(wcnt), 32'h0);
        check("wrap.gnt0", 32'(gnt0), 32'h0);
        check("wrap.gnt1", 32'(gnt1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
